// File: rtl/gpioemu_host.sv
`default_nettype none
// ============================================================================
// gpioemu_host : runs one 24x24 multiply/popcount job over the gpioemu bus
// Rev 1.0
// ============================================================================
module gpioemu_host #(
    parameter int unsigned STROBE_LEN = 2,
    parameter int unsigned START_WAIT = 4,
    parameter int unsigned POLL_GAP   = 2,
    parameter int unsigned POLL_MAX   = 255,
    parameter int unsigned W_READS    = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [23:0] cmd_a1,
    input  logic [23:0] cmd_a2,
    output logic        rsp_valid,
    output logic [31:0] rsp_w,
    output logic [23:0] rsp_l,
    output logic        rsp_ok,
    output logic        rsp_timeout,
    output logic [15:0] saddress,
    output logic        srd,
    output logic        swr,
    output logic [31:0] sdata_out,
    input  logic [31:0] sdata_in
);

    localparam logic [15:0] c_ADDR_A1   = 16'h037F;
    localparam logic [15:0] c_ADDR_A2   = 16'h0388;
    localparam logic [15:0] c_ADDR_CTL  = 16'h03A0;
    localparam logic [15:0] c_ADDR_W    = 16'h0390;
    localparam logic [15:0] c_ADDR_L    = 16'h0398;
    localparam logic [7:0]  c_STB_LAST  = 8'(STROBE_LEN - 1);
    localparam logic [7:0]  c_START_LST = 8'(START_WAIT - 1);
    localparam logic [7:0]  c_GAP_LAST  = 8'(POLL_GAP - 1);
    localparam logic [7:0]  c_POLL_LAST = 8'(POLL_MAX - 1);
    localparam logic [7:0]  c_WRD_LAST  = 8'(W_READS - 1);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_WR_A1 = 4'd1,
        S_WR_A2 = 4'd2,
        S_WR_GO = 4'd3,
        S_WAIT  = 4'd4,
        S_POLL  = 4'd5,
        S_RD_W  = 4'd6,
        S_RD_L  = 4'd7,
        S_RESP  = 4'd8
    } state_t;

    typedef enum logic [1:0] {
        PH_SETUP  = 2'd0,
        PH_STROBE = 2'd1,
        PH_HOLD   = 2'd2
    } phase_t;

    state_t      state_q, state_d;
    phase_t      phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [7:0]  poll_q, poll_d;
    logic [7:0]  wrd_q, wrd_d;
    logic [23:0] a1_q, a1_d, a2_q, a2_d;
    logic [31:0] w_q, w_d;
    logic        ok_q, ok_d;
    logic [31:0] rsp_w_q, rsp_w_d;
    logic [23:0] rsp_l_q, rsp_l_d;
    logic        rsp_ok_q, rsp_ok_d;
    logic        rsp_to_q, rsp_to_d;

    logic        w_access;
    logic        w_read;
    logic        w_done;
    logic [15:0] w_addr;
    logic [31:0] w_wdata;

    // Address/data decode: the state alone selects which register is accessed
    always_comb begin
        w_access = 1'b1;
        w_read   = 1'b0;
        w_addr   = 16'h0000;
        w_wdata  = 32'h0000_0000;
        case (state_q)
            S_WR_A1: begin w_addr = c_ADDR_A1;  w_wdata = {8'h00, a1_q}; end
            S_WR_A2: begin w_addr = c_ADDR_A2;  w_wdata = {8'h00, a2_q}; end
            S_WR_GO: w_addr = c_ADDR_CTL;
            S_POLL:  begin w_addr = c_ADDR_CTL; w_read = 1'b1; end
            S_RD_W:  begin w_addr = c_ADDR_W;   w_read = 1'b1; end
            S_RD_L:  begin w_addr = c_ADDR_L;   w_read = 1'b1; end
            default: w_access = 1'b0;
        endcase
    end

    assign w_done = w_access && (phase_q == PH_HOLD);

    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        cnt_d    = cnt_q;
        poll_d   = poll_q;
        wrd_d    = wrd_q;
        a1_d     = a1_q;
        a2_d     = a2_q;
        w_d      = w_q;
        ok_d     = ok_q;
        rsp_w_d  = rsp_w_q;
        rsp_l_d  = rsp_l_q;
        rsp_ok_d = rsp_ok_q;
        rsp_to_d = rsp_to_q;

        if (w_access) begin
            case (phase_q)
                PH_SETUP: begin
                    phase_d = PH_STROBE;
                    cnt_d   = 8'd0;
                end
                PH_STROBE: begin
                    if (cnt_q == c_STB_LAST) phase_d = PH_HOLD;
                    else                     cnt_d   = cnt_q + 8'd1;
                end
                default: phase_d = PH_SETUP;
            endcase
        end

        case (state_q)
            S_IDLE: begin
                poll_d  = 8'd0;
                wrd_d   = 8'd0;
                phase_d = PH_SETUP;
                if (cmd_valid) begin
                    a1_d    = cmd_a1;
                    a2_d    = cmd_a2;
                    state_d = S_WR_A1;
                end
            end
            S_WR_A1: if (w_done) state_d = S_WR_A2;
            S_WR_A2: if (w_done) state_d = S_WR_GO;
            S_WR_GO: begin
                if (w_done) begin
                    state_d = S_WAIT;
                    cnt_d   = c_START_LST;
                end
            end
            S_WAIT: begin
                if (cnt_q == 8'd0) state_d = S_POLL;
                else               cnt_d   = cnt_q - 8'd1;
            end
            S_POLL: begin
                if (w_done) begin
                    if (sdata_in[1]) begin
                        ok_d    = sdata_in[0];
                        state_d = S_RD_W;
                    end else if (poll_q == c_POLL_LAST) begin
                        // Give up: report zeros with the timeout flag
                        rsp_w_d  = 32'h0000_0000;
                        rsp_l_d  = 24'h00_0000;
                        rsp_ok_d = 1'b0;
                        rsp_to_d = 1'b1;
                        state_d  = S_RESP;
                    end else begin
                        poll_d  = poll_q + 8'd1;
                        cnt_d   = c_GAP_LAST;
                        state_d = S_WAIT;
                    end
                end
            end
            S_RD_W: begin
                if (w_done) begin
                    w_d = sdata_in;
                    if (wrd_q == c_WRD_LAST) state_d = S_RD_L;
                    else                     wrd_d   = wrd_q + 8'd1;
                end
            end
            S_RD_L: begin
                if (w_done) begin
                    rsp_w_d  = w_q;
                    rsp_l_d  = sdata_in[23:0];
                    rsp_ok_d = ok_q;
                    rsp_to_d = 1'b0;
                    state_d  = S_RESP;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            phase_q  <= PH_SETUP;
            cnt_q    <= 8'd0;
            poll_q   <= 8'd0;
            wrd_q    <= 8'd0;
            a1_q     <= 24'h00_0000;
            a2_q     <= 24'h00_0000;
            w_q      <= 32'h0000_0000;
            ok_q     <= 1'b0;
            rsp_w_q  <= 32'h0000_0000;
            rsp_l_q  <= 24'h00_0000;
            rsp_ok_q <= 1'b0;
            rsp_to_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            poll_q   <= poll_d;
            wrd_q    <= wrd_d;
            a1_q     <= a1_d;
            a2_q     <= a2_d;
            w_q      <= w_d;
            ok_q     <= ok_d;
            rsp_w_q  <= rsp_w_d;
            rsp_l_q  <= rsp_l_d;
            rsp_ok_q <= rsp_ok_d;
            rsp_to_q <= rsp_to_d;
        end
    end

    assign cmd_ready   = (state_q == S_IDLE);
    assign rsp_valid   = (state_q == S_RESP);
    assign rsp_w       = rsp_w_q;
    assign rsp_l       = rsp_l_q;
    assign rsp_ok      = rsp_ok_q;
    assign rsp_timeout = rsp_to_q;
    assign saddress    = w_addr;
    assign sdata_out   = w_wdata;
    assign srd         = w_access &&  w_read && (phase_q == PH_STROBE);
    assign swr         = w_access && !w_read && (phase_q == PH_STROBE);

endmodule
`default_nettype wire

// File: tb/tb_gpioemu_host.sv
`default_nettype none
// ============================================================================
// tb_gpioemu_host : random commands against a behavioural gpioemu peripheral
// Rev 1.0
// ============================================================================
module tb_gpioemu_host;

    localparam int STROBE_LEN = 2;
    localparam int START_WAIT = 4;
    localparam int POLL_GAP   = 2;
    localparam int POLL_MAX   = 3;
    localparam int W_READS    = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [23:0] cmd_a1;
    logic [23:0] cmd_a2;
    logic        rsp_valid;
    logic [31:0] rsp_w;
    logic [23:0] rsp_l;
    logic        rsp_ok;
    logic        rsp_timeout;
    logic [15:0] saddress;
    logic        srd;
    logic        swr;
    logic [31:0] sdata_out;
    logic [31:0] sdata_in;

    gpioemu_host #(
        .STROBE_LEN (STROBE_LEN),
        .START_WAIT (START_WAIT),
        .POLL_GAP   (POLL_GAP),
        .POLL_MAX   (POLL_MAX),
        .W_READS    (W_READS)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_a1      (cmd_a1),
        .cmd_a2      (cmd_a2),
        .rsp_valid   (rsp_valid),
        .rsp_w       (rsp_w),
        .rsp_l       (rsp_l),
        .rsp_ok      (rsp_ok),
        .rsp_timeout (rsp_timeout),
        .saddress    (saddress),
        .srd         (srd),
        .swr         (swr),
        .sdata_out   (sdata_out),
        .sdata_in    (sdata_in)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] w;
        logic [23:0] l;
        logic        ok;
        logic        to;
        int          polls;
        int          wreads;
    } exp_t;

    exp_t sb[$];
    int   lat_q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Peripheral model: registers captured at strobe rise; status answer frozen per poll
    logic [31:0] m_a1 = 0, m_a2 = 0, m_w = 0;
    logic [23:0] m_l = 0;
    logic        m_fits = 0;
    logic [1:0]  st_hold = 2'b00;
    int          nd_left = 0;

    assign sdata_in = (saddress == 16'h03A0) ? {30'b0, st_hold} :
                      (saddress == 16'h0390) ? m_w :
                      (saddress == 16'h0398) ? {8'hA5, m_l} : 32'hDEAD_BEEF;

    logic [15:0] wr_addr [3] = '{16'h037F, 16'h0388, 16'h03A0};
    logic        prev_srd = 0, prev_swr = 0, prev_rsp = 0;
    logic [15:0] prev_addr = 0, run_addr = 0;
    int          run = 0, polls = 0, wreads = 0, wr_idx = 0;
    logic        in_flight = 0, ready_viol = 0;

    always @(negedge clk) begin
        logic [63:0] prod;
        exp_t e;
        if (reset) begin
            prev_srd  = 0;
            prev_swr  = 0;
            prev_rsp  = 0;
            in_flight = 0;
            run       = 0;
        end else begin
            if ((srd || swr) && !(prev_srd || prev_swr)) begin
                chk("setup_addr", saddress, prev_addr);
                chk("no_overlap", srd & swr, 0);
                run      = 1;
                run_addr = saddress;
                if (swr) begin
                    chk("wr_count", wr_idx < 3, 1);
                    if (wr_idx < 3) chk("wr_order", saddress, wr_addr[wr_idx]);
                    wr_idx++;
                    if (saddress == 16'h037F) m_a1 = sdata_out;
                    if (saddress == 16'h0388) m_a2 = sdata_out;
                    if (saddress == 16'h03A0) begin
                        prod   = {32'b0, m_a1} * {32'b0, m_a2};
                        m_w    = prod[31:0];
                        m_l    = 24'($countones(prod[31:0]));
                        m_fits = (prod[63:32] == 32'b0);
                        chk("lat_queue", lat_q.size() != 0, 1);
                        nd_left = (lat_q.size() != 0) ? lat_q.pop_front() : 0;
                    end
                end else begin
                    if (saddress == 16'h03A0) begin
                        polls++;
                        st_hold = {nd_left == 0, m_fits};
                        if (nd_left > 0) nd_left--;
                    end
                    if (saddress == 16'h0390) wreads++;
                end
            end else if (srd || swr) begin
                run++;
                chk("strobe_addr", saddress, run_addr);
            end else if (prev_srd || prev_swr) begin
                chk("strobe_len", run, STROBE_LEN);
                chk("hold_addr", saddress, run_addr);
            end

            if (prev_rsp) chk("rsp_pulse", rsp_valid, 0);
            if (rsp_valid) begin
                chk("rsp_expected", sb.size() != 0, 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("rsp_w", rsp_w, e.w);
                    chk("rsp_l", rsp_l, e.l);
                    chk("rsp_ok", rsp_ok, e.ok);
                    chk("rsp_timeout", rsp_timeout, e.to);
                    chk("poll_reads", polls, e.polls);
                    chk("w_reads", wreads, e.wreads);
                    chk("ready_low_busy", ready_viol, 0);
                end
                in_flight = 0;
            end
            if (in_flight && cmd_ready) ready_viol = 1;
            if (cmd_valid && cmd_ready) begin
                in_flight  = 1;
                ready_viol = 0;
                polls      = 0;
                wreads     = 0;
                wr_idx     = 0;
            end
            prev_srd = srd;
            prev_swr = swr;
            prev_rsp = rsp_valid;
        end
        prev_addr = saddress;
    end

    // Reference: product from plain arithmetic; lat = not-done polls before done
    task automatic issue(input logic [23:0] a1, input logic [23:0] a2, input int lat,
                         input bit hold, input bit want);
        int n;
        logic [63:0] p;
        exp_t e;
        cmd_a1    = a1;
        cmd_a2    = a2;
        cmd_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (!cmd_ready && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("accept_in_time", cmd_ready, 1);
        if (cmd_ready) begin
            p = {40'b0, a1} * {40'b0, a2};
            if (lat >= POLL_MAX) begin
                e = '{w: 32'h0, l: 24'h0, ok: 1'b0, to: 1'b1, polls: POLL_MAX, wreads: 0};
            end else begin
                e = '{w: p[31:0], l: 24'($countones(p[31:0])), ok: (p < 64'h1_0000_0000),
                      to: 1'b0, polls: lat + 1, wreads: W_READS};
            end
            if (want) sb.push_back(e);
            lat_q.push_back(lat);
        end
        @(posedge clk);
        #1;
        if (!hold) cmd_valid = 1'b0;
    endtask

    function automatic logic [23:0] rnd_op();
        return 24'($urandom >> $urandom_range(8, 31));
    endfunction

    initial begin
        int n;
        reset     = 1'b1;
        cmd_valid = 1'b0;
        cmd_a1    = 24'h0;
        cmd_a2    = 24'h0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_cmd_ready", cmd_ready, 1);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_rsp_w", rsp_w, 0);
        chk("rst_rsp_l", rsp_l, 0);
        chk("rst_rsp_ok", rsp_ok, 0);
        chk("rst_rsp_timeout", rsp_timeout, 0);
        chk("rst_saddress", saddress, 0);
        chk("rst_strobes", {srd, swr}, 0);
        chk("rst_sdata_out", sdata_out, 0);
        @(posedge clk);
        #1 reset = 1'b0;

        issue(24'd3, 24'd5, 0, 1'b0, 1'b1);
        issue(24'hFFFFFF, 24'hFFFFFF, 2, 1'b0, 1'b1);
        issue(24'd7, 24'd11, POLL_MAX, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) issue(rnd_op(), rnd_op(), $urandom_range(0, 2), 1'b1, 1'b1);
        cmd_valid = 1'b0;
        for (int i = 0; i < 20; i++) begin
            issue(rnd_op(), rnd_op(), $urandom_range(0, 4), 1'b0, 1'b1);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // Abort in the middle of a status poll: no response may follow
        issue(24'd9, 24'd13, 1000, 1'b0, 1'b0);
        n = 0;
        while (!(srd && saddress == 16'h03A0) && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("reached_poll", srd && (saddress == 16'h03A0), 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_strobes", {srd, swr}, 0);
        chk("abort_ready", cmd_ready, 1);
        chk("abort_no_rsp", rsp_valid, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        issue(24'd123, 24'd456, 1, 1'b0, 1'b1);

        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_responses", sb.size(), 0);
        repeat (5) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        errors++;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
